// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - parametrised synchronous data memory with req/ack handshake and clear engine
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear request (restarts the clear engine)
//   req    in   access request
//   we     in   1 = write, 0 = read (qualified by req)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
//   ack    out  one-cycle completion pulse per accepted request
//   err    out  valid with ack; address was >= DEPTH
//   rdy    out  requests are accepted this cycle
module dmem_ctrl #(
    parameter int             DW        = 8,
    parameter int             AW        = 8,
    parameter int             DEPTH     = 256,
    parameter logic [AW-1:0]  INIT_ADDR = AW'(8'h83),
    parameter logic [DW-1:0]  INIT_VAL  = DW'(8'h22)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          err,
    output logic          rdy
);

    // cnt must be able to hold DEPTH itself so it parks without wrapping.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    typedef enum logic {
        S_CLR = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic          clr_we;
    logic          acc;
    logic          in_range;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [IW-1:0] rd_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and clear-engine write strobe
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            S_CLR: begin
                if (clr) begin
                    cnt_nxt = '0;
                end else begin
                    clr_we  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_nxt = S_CLR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_CLR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // rdy is a pure decode of the state register, so it never depends on req or clr.
    assign rdy      = (state == S_RUN);
    assign acc      = req && rdy && !clr;
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign rd_idx   = IW'(addr);

    // Single write port shared by the clear engine and accepted writes; the two
    // never collide because requests are only accepted in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = IW'(cnt);
            mem_wdata = (cnt == CW'(INIT_ADDR)) ? INIT_VAL : '0;
        end else if (acc && we && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = IW'(addr);
            mem_wdata = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Response registers: reads sample the array before any same-edge write
    // lands, and a write followed by a read next cycle sees the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= acc;
            err <= acc && !in_range;
            if (acc) begin
                if (!in_range) begin
                    rdata <= '0;
                end else if (!we) begin
                    rdata <= mem[rd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       err;
    logic       rdy;

    logic       req2;
    logic       we2;
    logic [7:0] addr2;
    logic [7:0] wdata2;
    logic [7:0] rdata2;
    logic       ack2;
    logic       err2;
    logic       rdy2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] rd;
        logic       e;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[13];

    dmem_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .rdy   (rdy)
    );

    dmem_ctrl #(.DEPTH(200)) u_dut200 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .req   (req2),
        .we    (we2),
        .addr  (addr2),
        .wdata (wdata2),
        .rdata (rdata2),
        .ack   (ack2),
        .err   (err2),
        .rdy   (rdy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the main DUT; an expected response is queued when the
    // bench predicts acceptance and is popped when ack appears.
    task automatic cycle_main(input logic r, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic c, input logic accept,
                              input logic [7:0] exp_rd, input logic exp_e);
        exp_t x;
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        clr   = c;
        @(posedge clk);
        if (accept) begin
            x.rd = exp_rd;
            x.e  = exp_e;
            exp_q.push_back(x);
        end
        #1;
        chk("ack", 32'(ack), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("rdata", 32'(rdata), 32'(x.rd));
            chk("err", 32'(err), 32'(x.e));
        end
        clr = 1'b0;
    endtask

    task automatic wait_rdy(input string name, input int exp_edges);
        int n;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            cycle_main(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            if (rdy) begin
                n = i;
                break;
            end
        end
        chk(name, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        int rdy_edge;

        vecs[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 8'h20, 8'h3C, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 8'h21, 8'hC3, 8'hA5, 1'b0};
        vecs[4]  = '{1'b0, 8'h20, 8'h00, 8'h3C, 1'b0};
        vecs[5]  = '{1'b0, 8'h21, 8'h00, 8'hC3, 1'b0};
        vecs[6]  = '{1'b0, 8'h83, 8'h00, 8'h22, 1'b0};
        vecs[7]  = '{1'b1, 8'h83, 8'h5A, 8'h22, 1'b0};
        vecs[8]  = '{1'b0, 8'h83, 8'h00, 8'h5A, 1'b0};
        vecs[9]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 8'h77, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h77, 1'b0};
        vecs[12] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};

        rst_n  = 1'b0;
        clr    = 1'b0;
        req    = 1'b1;
        we     = 1'b0;
        addr   = 8'h83;
        wdata  = 8'h00;
        req2   = 1'b0;
        we2    = 1'b0;
        addr2  = 8'h00;
        wdata2 = 8'h00;

        // Reset values, with a read request held throughout the clear.
        #2;
        chk("reset_rdy", 32'(rdy), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_edge = 0;
        for (int n = 1; n <= 300; n++) begin
            cycle_main(1'b1, 1'b0, 8'h83, 8'h00, 1'b0, n == 257, 8'h22, 1'b0);
            if (rdy && rdy_edge == 0) rdy_edge = n;
            if (n == 257) break;
        end
        chk("clear_edges_after_reset", 32'(rdy_edge), 32'd256);

        // Sweep every address after the clear.
        for (int a = 0; a < 256; a++) begin
            cycle_main(1'b1, 1'b0, 8'(a), 8'h00, 1'b0, 1'b1,
                       (a == 8'h83) ? 8'h22 : 8'h00, 1'b0);
        end

        // Back-to-back table of accesses.
        for (int i = 0; i < 13; i++) begin
            cycle_main(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b1,
                       vecs[i].exp_rdata, vecs[i].exp_err);
        end
        cycle_main(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Out-of-range access on the 200-word instance.
        chk("oor_rdy", 32'(rdy2), 32'h1);
        req2 = 1'b1; we2 = 1'b0; addr2 = 8'h83;
        @(posedge clk); #1;
        chk("oor_pre_ack", 32'(ack2), 32'h1);
        chk("oor_pre_rdata", 32'(rdata2), 32'h22);
        we2 = 1'b1; addr2 = 8'd210; wdata2 = 8'hFF;
        @(posedge clk); #1;
        chk("oor_wr_ack", 32'(ack2), 32'h1);
        chk("oor_wr_err", 32'(err2), 32'h1);
        chk("oor_wr_rdata", 32'(rdata2), 32'h0);
        we2 = 1'b0;
        @(posedge clk); #1;
        chk("oor_rd_ack", 32'(ack2), 32'h1);
        chk("oor_rd_err", 32'(err2), 32'h1);
        chk("oor_rd_rdata", 32'(rdata2), 32'h0);
        for (int a = 0; a < 200; a++) begin
            addr2 = 8'(a);
            @(posedge clk); #1;
            chk("oor_sweep_err", 32'(err2), 32'h0);
            chk("oor_sweep_rdata", 32'(rdata2), (a == 8'h83) ? 32'h22 : 32'h0);
        end
        req2 = 1'b0;
        @(posedge clk); #1;
        chk("oor_idle_ack", 32'(ack2), 32'h0);

        // Clear collision, with an ack from the previous cycle still due.
        cycle_main(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
        cycle_main(1'b1, 1'b1, 8'h20, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("collision_rdy", 32'(rdy), 32'h0);
        wait_rdy("clear_edges_after_clr", 256);
        cycle_main(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle_main(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle_main(1'b1, 1'b0, 8'h83, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0);

        // Reset while an ack is pending, then again mid-clear.
        cycle_main(1'b1, 1'b1, 8'h40, 8'h99, 1'b0, 1'b1, 8'h22, 1'b0);
        cycle_main(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0);
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ack", 32'(ack), 32'h0);
        chk("async_err", 32'(err), 32'h0);
        chk("async_rdata", 32'(rdata), 32'h0);
        chk("async_rdy", 32'(rdy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle_main(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("midclr_rdy", 32'(rdy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_rdy("clear_edges_after_midclr_reset", 256);
        cycle_main(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle_main(1'b1, 1'b0, 8'h83, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0);
        cycle_main(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
